// File: rtl/sparhixcel_pkg.sv
// Shared definitions for the feature-register sequencer.
//   - default widths for the sequencer parameters
//   - FSM state enum
//   - 16-bit saturating add used by the optional performance counters
//     (FREG_SEQ_PERF_EN)
package sparhixcel_pkg;

    localparam int FREG_N_DEF         = 3;
    localparam int FREG_I_WIDTH_DEF   = 8;
    localparam int FREG_LEN_WIDTH_DEF = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FILL,
        S_RUN,
        S_WAIT,
        S_DONE
    } freg_state_e;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/freg_tap_pick.sv
// Next-set-bit search over the nonzero-tap mask.
//   mask_i : latched nonzero-tap mask
//   cur_i  : first index that may be selected
//   next_o : lowest set index >= cur_i (0 when none)
//   last_o : no set bit above next_o; also 1 for an empty search
module freg_tap_pick
    import sparhixcel_pkg::*;
#(
    parameter int N         = FREG_N_DEF,
    parameter int SEL_WIDTH = $clog2(N)
) (
    input  logic [N-1:0]         mask_i,
    input  logic [SEL_WIDTH-1:0] cur_i,
    output logic [SEL_WIDTH-1:0] next_o,
    output logic                 last_o
);

    always_comb begin
        logic found;
        found  = 1'b0;
        next_o = '0;
        last_o = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (mask_i[i] && (i >= int'(cur_i))) begin
                if (!found) begin
                    next_o = SEL_WIDTH'(i);
                    found  = 1'b1;
                end else begin
                    last_o = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/freg_sequencer.sv
// Sequencer for the sparse-kernel input shift register.
// Clears the shift register, fills it with N features, then walks every
// window of the row emitting the nonzero taps of the latched mask, shifting
// in one new feature between windows.
//   clk_i, rst_n_i            : clock, async active-low reset
//   start_i, row_len_i,
//   nz_mask_i                 : row command (sampled in IDLE)
//   feat_valid_i/feat_ready_o/
//   feat_data_i               : feature source handshake
//   freg_rst_o, shift_en_o,
//   in_feature_o              : shift-register control and data
//   f_sel_o, sel_valid_o,
//   win_last_o                : tap select stream
//   busy_o, done_o, err_o     : status
// Optional: FREG_SEQ_PERF_EN adds stall_cnt_o / skip_cnt_o.
module freg_sequencer
    import sparhixcel_pkg::*;
#(
    parameter int N         = FREG_N_DEF,
    parameter int I_WIDTH   = FREG_I_WIDTH_DEF,
    parameter int SEL_WIDTH = $clog2(N),
    parameter int LEN_WIDTH = FREG_LEN_WIDTH_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 start_i,
    input  logic [LEN_WIDTH-1:0] row_len_i,
    input  logic [N-1:0]         nz_mask_i,
    input  logic                 feat_valid_i,
    output logic                 feat_ready_o,
    input  logic [I_WIDTH-1:0]   feat_data_i,
    output logic                 freg_rst_o,
    output logic                 shift_en_o,
    output logic [I_WIDTH-1:0]   in_feature_o,
    output logic [SEL_WIDTH-1:0] f_sel_o,
    output logic                 sel_valid_o,
    output logic                 win_last_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
`ifdef FREG_SEQ_PERF_EN
    ,
    output logic [15:0]          stall_cnt_o,
    output logic [15:0]          skip_cnt_o
`endif
);

    localparam logic [LEN_WIDTH-1:0] N_L       = LEN_WIDTH'(N);
    localparam logic [LEN_WIDTH-1:0] FILL_LAST = LEN_WIDTH'(N - 1);

    freg_state_e            state_q, state_d;
    logic [LEN_WIDTH-1:0]   len_q;
    logic [N-1:0]           mask_q;
    logic [LEN_WIDTH-1:0]   win_q, win_d;     // windows already completed
    logic [LEN_WIDTH-1:0]   fill_q, fill_d;   // FILL handshakes so far
    logic [SEL_WIDTH-1:0]   idx_q, idx_d;     // search start inside window
    logic                   rst_hold_q;       // keeps freg_rst_o up until first clock after reset
    logic [SEL_WIDTH-1:0]   pick_idx;
    logic                   pick_last;
    logic                   start_ok;
    logic                   final_win;

    freg_tap_pick #(.N(N), .SEL_WIDTH(SEL_WIDTH)) u_pick (
        .mask_i (mask_q),
        .cur_i  (idx_q),
        .next_o (pick_idx),
        .last_o (pick_last)
    );

    assign final_win    = (win_q == len_q - N_L);
    assign busy_o       = (state_q != S_IDLE);
    assign freg_rst_o   = rst_hold_q | (state_q == S_CLEAR);
    assign in_feature_o = shift_en_o ? feat_data_i : '0;

    always_comb begin
        state_d      = state_q;
        win_d        = win_q;
        fill_d       = fill_q;
        idx_d        = idx_q;
        start_ok     = 1'b0;
        feat_ready_o = 1'b0;
        shift_en_o   = 1'b0;
        sel_valid_o  = 1'b0;
        f_sel_o      = '0;
        win_last_o   = 1'b0;
        done_o       = 1'b0;
        err_o        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (row_len_i >= N_L) begin
                        start_ok = 1'b1;
                        state_d  = S_CLEAR;
                        win_d    = '0;
                        fill_d   = '0;
                        idx_d    = '0;
                    end else begin
                        // keep err_o quiet while reset is held
                        err_o = rst_n_i;
                    end
                end
            end
            S_CLEAR: state_d = S_FILL;
            S_FILL: begin
                feat_ready_o = 1'b1;
                if (feat_valid_i) begin
                    shift_en_o = 1'b1;
                    if (fill_q == FILL_LAST) state_d = S_RUN;
                    else                     fill_d  = fill_q + 1'b1;
                end
            end
            S_RUN: begin
                // an empty mask still spends one marker cycle per window
                sel_valid_o = |mask_q;
                f_sel_o     = (|mask_q) ? pick_idx : '0;
                win_last_o  = pick_last;
                if (!pick_last) begin
                    idx_d = pick_idx + 1'b1;
                end else begin
                    idx_d = '0;
                    if (final_win) begin
                        state_d = S_DONE;
                    end else begin
                        // next feature is taken on the window's last cycle so
                        // the following window starts without a bubble
                        feat_ready_o = 1'b1;
                        if (feat_valid_i) begin
                            shift_en_o = 1'b1;
                            win_d      = win_q + 1'b1;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end
                end
            end
            S_WAIT: begin
                feat_ready_o = 1'b1;
                if (feat_valid_i) begin
                    shift_en_o = 1'b1;
                    win_d      = win_q + 1'b1;
                    state_d    = S_RUN;
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            mask_q     <= '0;
            win_q      <= '0;
            fill_q     <= '0;
            idx_q      <= '0;
            rst_hold_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            fill_q     <= fill_d;
            idx_q      <= idx_d;
            rst_hold_q <= 1'b0;
            if (start_ok) begin
                len_q  <= row_len_i;
                mask_q <= nz_mask_i;
            end
        end
    end

`ifdef FREG_SEQ_PERF_EN
    localparam logic [15:0] N16 = 16'(N);

    logic [15:0] stall_q, skip_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_q <= '0;
            skip_q  <= '0;
        end else if (start_ok) begin
            stall_q <= '0;
            skip_q  <= '0;
        end else begin
            if (state_q == S_WAIT)
                stall_q <= sat_add16(stall_q, 16'd1);
            // zero taps of a window are accounted once, on its last cycle
            if (state_q == S_RUN && pick_last)
                skip_q <= sat_add16(skip_q, N16 - 16'($countones(mask_q)));
        end
    end

    assign stall_cnt_o = stall_q;
    assign skip_cnt_o  = skip_q;
`endif

endmodule

// File: tb/tb_freg_sequencer.sv
// Self-checking bench for freg_sequencer (default build, N=3).
module tb_freg_sequencer;

    localparam int N  = 3;
    localparam int IW = 8;
    localparam int SW = 2;
    localparam int LW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [LW-1:0] row_len = '0;
    logic [N-1:0]  mask = '0;
    logic          feat_valid = 1'b0;
    logic [IW-1:0] feat_data = '0;

    logic          feat_ready_o, freg_rst_o, shift_en_o, sel_valid_o;
    logic          win_last_o, busy_o, done_o, err_o;
    logic [IW-1:0] in_feature_o;
    logic [SW-1:0] f_sel_o;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int sel;
        bit vld;
        bit last;
        int win;
    } exp_t;

    freg_sequencer #(.N(N), .I_WIDTH(IW), .SEL_WIDTH(SW), .LEN_WIDTH(LW)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .start_i      (start),
        .row_len_i    (row_len),
        .nz_mask_i    (mask),
        .feat_valid_i (feat_valid),
        .feat_ready_o (feat_ready_o),
        .feat_data_i  (feat_data),
        .freg_rst_o   (freg_rst_o),
        .shift_en_o   (shift_en_o),
        .in_feature_o (in_feature_o),
        .f_sel_o      (f_sel_o),
        .sel_valid_o  (sel_valid_o),
        .win_last_o   (win_last_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    // Drives one row and checks it against a transaction-level model:
    // expected tap stream per window, feature order, WAIT cycles and latency.
    // gmode: 0 source always valid, 1 random gaps, 2 four-cycle gap after window 0.
    // abort_at >= 0 asserts reset in that cycle and returns.
    task automatic run_row(input int len, input logic [N-1:0] m, input int gmode, input int abort_at);
        logic [IW-1:0] feats[$];
        int   gaps[$];
        exp_t expq[$];
        exp_t e;
        int   windows, slots, gsum, gwait, fi, wl, shifts, cyc, waits, done_cyc, hi, g;
        bit   fin;
        windows = len - N + 1;
        slots   = ($countones(m) == 0) ? 1 : $countones(m);
        gsum = 0; gwait = 0;
        for (int k = 0; k < len; k++) begin
            feats.push_back(IW'($urandom));
            g = 0;
            if (gmode == 1 && ($urandom % 3 == 0)) g = $urandom_range(1, 3);
            if (gmode == 2 && k == N) g = 4;
            gaps.push_back(g);
            gsum += g;
            if (k >= N) gwait += g;
        end
        hi = -1;
        for (int i = 0; i < N; i++) if (m[i]) hi = i;
        for (int w = 0; w < windows; w++) begin
            if (m == '0) expq.push_back('{0, 1'b0, 1'b1, w});
            else for (int i = 0; i < N; i++)
                if (m[i]) expq.push_back('{i, 1'b1, (i == hi), w});
        end
        fi = 0; wl = gaps[0]; shifts = 0; cyc = 0; waits = 0; done_cyc = -1; fin = 0;
        while (!fin && cyc < 500) begin
            @(posedge clk); #1;
            start      = (cyc == 0) ? 1'b1 : ($urandom % 4 == 0);
            row_len    = (cyc == 0) ? LW'(len) : LW'($urandom);
            mask       = (cyc == 0) ? m : N'($urandom);
            feat_valid = (fi < len) && (wl == 0);
            feat_data  = feat_valid ? feats[fi] : IW'($urandom);
            @(negedge clk);
            n_cmp++;
            if (err_o !== 1'b0) begin n_bad++; $display("FAIL err_in_row: cyc %0d err_o=%b want 0", cyc, err_o); end
            n_cmp++;
            if (freg_rst_o !== (cyc == 1)) begin n_bad++; $display("FAIL clear_pulse: cyc %0d freg_rst_o=%b want %b", cyc, freg_rst_o, cyc == 1); end
            n_cmp++;
            if (busy_o !== (cyc >= 1)) begin n_bad++; $display("FAIL busy: cyc %0d busy_o=%b want %b", cyc, busy_o, cyc >= 1); end
            n_cmp++;
            if (shift_en_o !== (feat_ready_o & feat_valid)) begin
                n_bad++; $display("FAIL shift_hs: cyc %0d shift_en_o=%b want %b", cyc, shift_en_o, feat_ready_o & feat_valid);
            end
            if (sel_valid_o || win_last_o) begin
                if (expq.size() == 0) begin
                    n_cmp++; n_bad++; $display("FAIL extra_sel: cyc %0d f_sel_o=%0d want no tap", cyc, f_sel_o);
                end else begin
                    e = expq.pop_front();
                    n_cmp++;
                    if ({sel_valid_o, win_last_o} !== {e.vld, e.last} || (e.vld && f_sel_o !== SW'(e.sel))) begin
                        n_bad++;
                        $display("FAIL tap_seq: cyc %0d got sel=%0d v=%b l=%b want sel=%0d v=%b l=%b",
                                 cyc, f_sel_o, sel_valid_o, win_last_o, e.sel, e.vld, e.last);
                    end
                    n_cmp++;
                    if (shifts !== N + e.win) begin
                        n_bad++; $display("FAIL window_data: cyc %0d shifted=%0d want %0d", cyc, shifts, N + e.win);
                    end
                end
            end
            if (shifts >= N && busy_o && feat_ready_o && !sel_valid_o && !win_last_o) waits++;
            if (shift_en_o) begin
                n_cmp++;
                if (shifts >= len || in_feature_o !== feats[shifts]) begin
                    n_bad++; $display("FAIL feature: cyc %0d in_feature_o=%0h want %0h", cyc, in_feature_o,
                                      (shifts < len) ? feats[shifts] : 8'h00);
                end
                shifts++;
            end
            if (feat_ready_o && feat_valid) begin
                fi++;
                wl = (fi < len) ? gaps[fi] : 0;
            end else if (feat_ready_o && wl > 0) begin
                wl--;
            end
            if (done_o) begin fin = 1; done_cyc = cyc; end
            if (cyc == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                n_cmp++;
                if ({freg_rst_o, feat_ready_o, busy_o, sel_valid_o, shift_en_o} !== 5'b10000) begin
                    n_bad++; $display("FAIL mid_reset: rst/rdy/busy/sel/shift=%b want 10000",
                                      {freg_rst_o, feat_ready_o, busy_o, sel_valid_o, shift_en_o});
                end
                @(posedge clk); #1;
                start = 1'b0; feat_valid = 1'b0; rst_n = 1'b1;
                @(negedge clk);
                n_cmp++;
                if ({freg_rst_o, busy_o} !== 2'b10) begin
                    n_bad++; $display("FAIL reset_release: rst/busy=%b want 10", {freg_rst_o, busy_o});
                end
                return;
            end
            cyc++;
        end
        start = 1'b0;
        n_cmp++;
        if (!fin) begin n_bad++; $display("FAIL done_timeout: no done_o within %0d cycles, want done", cyc); end
        n_cmp++;
        // latency counted in clock edges from the edge that samples start
        if (done_cyc - 1 !== 1 + N + gsum + windows * slots) begin
            n_bad++; $display("FAIL latency: done after %0d edges want %0d", done_cyc - 1, 1 + N + gsum + windows * slots);
        end
        n_cmp++;
        if (shifts !== len) begin n_bad++; $display("FAIL shift_count: got %0d want %0d", shifts, len); end
        n_cmp++;
        if (expq.size() !== 0) begin n_bad++; $display("FAIL missing_taps: %0d left want 0", expq.size()); end
        n_cmp++;
        if (waits !== gwait) begin n_bad++; $display("FAIL wait_cycles: got %0d want %0d", waits, gwait); end
        @(posedge clk); #1;
        feat_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy_o, done_o} !== 2'b00) begin n_bad++; $display("FAIL back_to_idle: busy/done=%b want 00", {busy_o, done_o}); end
    endtask

    task automatic test_reset();
        start = 1'b1; row_len = LW'(2);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (freg_rst_o !== 1'b1) begin n_bad++; $display("FAIL reset_freg_rst: got %b want 1", freg_rst_o); end
        n_cmp++;
        if ({busy_o, done_o, err_o, feat_ready_o, shift_en_o, sel_valid_o, win_last_o, f_sel_o, in_feature_o} !== '0) begin
            n_bad++; $display("FAIL reset_outputs: got %0h want 0",
                {busy_o, done_o, err_o, feat_ready_o, shift_en_o, sel_valid_o, win_last_o, f_sel_o, in_feature_o});
        end
        start = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (freg_rst_o !== 1'b1) begin n_bad++; $display("FAIL release_hold: got %b want 1", freg_rst_o); end
        @(negedge clk);
        n_cmp++;
        if ({freg_rst_o, busy_o, feat_ready_o} !== 3'b000) begin
            n_bad++; $display("FAIL release_clear: rst/busy/rdy=%b want 000", {freg_rst_o, busy_o, feat_ready_o});
        end
    endtask

    task automatic test_full_mask();
        run_row(5, 3'b111, 0, -1);
    endtask

    task automatic test_sparse();
        run_row(5, 3'b101, 0, -1);
        run_row(3, 3'b010, 0, -1);
    endtask

    task automatic test_zero_mask();
        run_row(4, 3'b000, 0, -1);
    endtask

    task automatic test_stall();
        run_row(6, 3'b111, 2, -1);
    endtask

    task automatic test_err();
        int lens[2] = '{2, 0};
        foreach (lens[k]) begin
            @(posedge clk); #1;
            start = 1'b1; row_len = LW'(lens[k]); mask = 3'b111;
            @(negedge clk);
            n_cmp++;
            if ({err_o, busy_o} !== 2'b10) begin n_bad++; $display("FAIL err_pulse: len %0d err/busy=%b want 10", lens[k], {err_o, busy_o}); end
            @(posedge clk); #1 start = 1'b0;
            @(negedge clk);
            n_cmp++;
            if ({err_o, busy_o} !== 2'b00) begin n_bad++; $display("FAIL err_after: len %0d err/busy=%b want 00", lens[k], {err_o, busy_o}); end
        end
    endtask

    task automatic test_mid_reset();
        run_row(6, 3'b111, 0, 8);
        run_row(5, 3'b011, 0, -1);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 8; r++)
            run_row($urandom_range(3, 9), N'($urandom), 1, -1);
    endtask

    initial begin
        test_reset();
        test_full_mask();
        test_sparse();
        test_zero_mask();
        test_stall();
        test_err();
        test_mid_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
